// File: rtl/instr_decode_issue.sv
// instr_decode_issue: buffers fetched words in a FIFO, decodes and issues one op per cycle, stalls on multiply
module instr_decode_issue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          id_rst,
  input  logic          id_en,
  input  logic [25:0]   id_IW,
  input  logic          id_mm_done,
  output logic          id_mm_start,
  output logic          id_we,
  output logic [1:0]    id_alu_op,
  output logic [4:0]    id_rd,
  output logic [4:0]    id_rs,
  output logic [4:0]    id_rt,
  output logic [16:0]   id_imm,
  output logic [CW-1:0] id_count,
  output logic          id_overflow,
  output logic          id_illegal,
  output logic          id_halted
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, MM_WAIT, HALTED} state_t;
  state_t state, state_nx;
  logic [25:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [25:0] head;
  logic [3:0] op;
  logic push_req, push, pop;
  assign head = mem[rp];
  assign op = head[25:22];
  assign id_halted = state == HALTED;
  // A full FIFO still accepts a word when the head leaves on the same edge
  always_comb begin
    push_req = id_en && state != HALTED && id_IW[25:22] != 4'd0;
    pop = state == RUN && id_count != '0;
    push = push_req && (id_count != CW'(DEPTH) || pop);
    state_nx = state;
    if (state == MM_WAIT && id_mm_done) state_nx = RUN;
    else if (pop) state_nx = op == 4'd4 ? MM_WAIT : op == 4'd15 ? HALTED : RUN;
  end
  // State register; reset abandons any multiply in flight
  always_ff @(posedge clk)
    if (id_rst) state <= RUN;
    else state <= state_nx;
  // FIFO storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk)
    if (push) mem[wp] <= id_IW;
  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk)
    if (id_rst) begin
      wp <= '0;
      rp <= '0;
      id_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      id_count <= id_count + CW'(push) - CW'(pop);
    end
  // Issue: strobes pulse for one cycle, fields hold until the next issue
  always_ff @(posedge clk)
    if (id_rst) begin
      id_we <= 1'b0;
      id_mm_start <= 1'b0;
      id_alu_op <= '0;
      id_rd <= '0;
      id_rs <= '0;
      id_rt <= '0;
      id_imm <= '0;
      id_overflow <= 1'b0;
      id_illegal <= 1'b0;
    end else begin
      id_we <= pop && op >= 4'd1 && op <= 4'd3;
      id_mm_start <= pop && op == 4'd4;
      id_overflow <= id_overflow | (push_req & ~push);
      id_illegal <= id_illegal | (pop && op >= 4'd5 && op <= 4'd14);
      if (pop && op >= 4'd1 && op <= 4'd4) begin
        id_rd <= head[21:17];
        id_rs <= head[16:12];
        id_rt <= head[11:7];
      end
      if (pop && op >= 4'd1 && op <= 4'd3) begin
        id_alu_op <= op[1:0] - 2'd1;
        id_imm <= head[16:0];
      end
    end
endmodule

// File: tb/tb_instr_decode_issue.sv
// tb_instr_decode_issue: directed checks of decode/issue, FIFO limits, multiply stall, halt and reset
module tb_instr_decode_issue;
  logic clk = 1'b0;
  logic rst, en, mm_done;
  logic [25:0] iw;
  logic mm_start, we, overflow, illegal, halted;
  logic [1:0] alu_op;
  logic [4:0] rd, rs, rt;
  logic [16:0] imm;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  int pulses;
  instr_decode_issue #(.DEPTH(4)) dut (
    .clk(clk), .id_rst(rst), .id_en(en), .id_IW(iw), .id_mm_done(mm_done),
    .id_mm_start(mm_start), .id_we(we), .id_alu_op(alu_op), .id_rd(rd), .id_rs(rs),
    .id_rt(rt), .id_imm(imm), .id_count(count), .id_overflow(overflow),
    .id_illegal(illegal), .id_halted(halted)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [25:0] w(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {op, d, s, t, 7'd0};
  endfunction
  task automatic do_reset;
    rst = 1'b1;
    en = 1'b0;
    mm_done = 1'b0;
    iw = '0;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    do_reset;
    chk("rst_count", count, 0);
    chk("rst_we", we, 0);
    chk("rst_start", mm_start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_fields", {alu_op, rd, rs, rt, imm}, 0);
    en = 1'b1;
    iw = {4'd1, 5'd3, 17'h1ABCD};
    tick;
    chk("t1_c1_we", we, 0);
    chk("t1_c1_count", count, 1);
    iw = w(4'd2, 5'd4, 5'd3, 5'd3);
    tick;
    chk("t1_c2_we", we, 1);
    chk("t1_c2_alu", alu_op, 0);
    chk("t1_c2_imm", imm, 32'h1ABCD);
    chk("t1_c2_rd", rd, 3);
    chk("t1_c2_count", count, 1);
    en = 1'b0;
    tick;
    chk("t1_c3_we", we, 1);
    chk("t1_c3_alu", alu_op, 1);
    chk("t1_c3_rd", rd, 4);
    chk("t1_c3_rs", rs, 3);
    chk("t1_c3_count", count, 0);
    tick;
    chk("t1_c4_we", we, 0);
    chk("t1_c4_rd_hold", rd, 4);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      en = i < 8;
      iw = i[0] ? w(4'd3, 5'(i), 5'd1, 5'd2) : 26'd0;
      tick;
      if (we) begin
        pulses++;
        chk("nop_alu", alu_op, 2);
      end
    end
    chk("nop_pulses", pulses, 4);
    chk("nop_count", count, 0);
    do_reset;
    en = 1'b1;
    iw = w(4'd4, 5'd9, 5'd1, 5'd2);
    tick;
    iw = w(4'd2, 5'd1, 5'd0, 5'd0);
    tick;
    chk("full_start", mm_start, 1);
    chk("full_mul_fields", {rd, rs, rt}, {5'd9, 5'd1, 5'd2});
    for (int i = 2; i <= 4; i++) begin
      iw = w(4'd2, 5'(i), 5'd0, 5'd0);
      tick;
      chk("full_start_once", mm_start, 0);
    end
    chk("full_count4", count, 4);
    en = 1'b0;
    mm_done = 1'b1;
    tick;
    chk("full_done_we", we, 0);
    chk("full_done_count", count, 4);
    mm_done = 1'b0;
    en = 1'b1;
    iw = w(4'd2, 5'd5, 5'd0, 5'd0);
    tick;
    chk("full_pp_we", we, 1);
    chk("full_pp_rd", rd, 1);
    chk("full_pp_count", count, 4);
    chk("full_pp_ovf", overflow, 0);
    iw = w(4'd2, 5'd6, 5'd0, 5'd0);
    tick;
    chk("full_pp2_rd", rd, 2);
    chk("full_pp2_count", count, 4);
    en = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      tick;
      chk("full_drain_we", we, 1);
      chk("full_drain_rd", rd, i);
    end
    chk("full_drain_count", count, 0);
    chk("full_ovf_end", overflow, 0);
    do_reset;
    pulses = 0;
    en = 1'b1;
    iw = w(4'd4, 5'd20, 5'd3, 5'd4);
    tick;
    for (int i = 11; i <= 16; i++) begin
      iw = w(4'd2, 5'(i), 5'd0, 5'd0);
      tick;
      if (mm_start) pulses++;
      chk("ovf_no_we", we, 0);
    end
    chk("ovf_starts", pulses, 1);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    en = 1'b0;
    mm_done = 1'b1;
    tick;
    chk("ovf_m_we", we, 0);
    mm_done = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      tick;
      chk("ovf_issue_we", we, 1);
      chk("ovf_issue_rd", rd, i);
    end
    tick;
    chk("ovf_lost_we", we, 0);
    chk("ovf_lost_count", count, 0);
    do_reset;
    en = 1'b1;
    iw = w(4'd7, 5'd1, 5'd1, 5'd1);
    tick;
    iw = w(4'd15, 5'd0, 5'd0, 5'd0);
    tick;
    chk("ill_flag", illegal, 1);
    chk("ill_we", we, 0);
    en = 1'b0;
    tick;
    chk("halt_flag", halted, 1);
    chk("halt_count", count, 0);
    en = 1'b1;
    iw = {4'd1, 5'd7, 17'h00055};
    mm_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      mm_done = 1'b0;
      chk("halt_ldi_we", we, 0);
      chk("halt_ldi_count", count, 0);
      chk("halt_stays", halted, 1);
    end
    do_reset;
    chk("halt_rst_exit", halted, 0);
    en = 1'b1;
    iw = w(4'd4, 5'd8, 5'd1, 5'd1);
    tick;
    for (int i = 1; i <= 3; i++) begin
      iw = w(4'd2, 5'(i), 5'd0, 5'd0);
      tick;
    end
    chk("mr_count3", count, 3);
    rst = 1'b1;
    iw = w(4'd2, 5'd9, 5'd0, 5'd0);
    tick;
    chk("mr_count", count, 0);
    chk("mr_we", we, 0);
    chk("mr_start", mm_start, 0);
    chk("mr_rd", rd, 0);
    rst = 1'b0;
    en = 1'b0;
    mm_done = 1'b1;
    tick;
    mm_done = 1'b0;
    chk("mr_done_we", we, 0);
    tick;
    chk("mr_done_we2", we, 0);
    chk("mr_done_count", count, 0);
    en = 1'b1;
    iw = {4'd1, 5'd2, 17'h00123};
    tick;
    en = 1'b0;
    tick;
    chk("mr_run_we", we, 1);
    chk("mr_run_imm", imm, 32'h123);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
